// File: rtl/ysyx_23060077_riscv_issue_ctrl.sv
// Issue controller: per-register busy scoreboard that stalls RAW/WAW hazards
// and hands hazard-free instructions to execute through a one-entry output register.
module ysyx_23060077_riscv_issue_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NR_REG         = 32,
    parameter int INST_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [INST_WIDTH-1:0]     in_inst,
    input  logic [REG_ADDR_WIDTH-1:0] in_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] in_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd,
    input  logic                      in_rd_wen,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [INST_WIDTH-1:0]     out_inst,
    output logic [REG_ADDR_WIDTH-1:0] out_rs1,
    output logic [REG_ADDR_WIDTH-1:0] out_rs2,
    output logic [REG_ADDR_WIDTH-1:0] out_rd,
    output logic                      out_rd_wen,
    input  logic                      wb_valid,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input  logic                      flush,
    output logic [NR_REG-1:0]         busy_mask,
    output logic [31:0]               stall_cnt
);

    logic [NR_REG-1:0] busy;
    logic [NR_REG-1:0] clr_vec;
    logic [NR_REG-1:0] set_vec;
    logic [NR_REG-1:0] eff_busy;
    logic              hazard;
    logic              accept;

    // Writebacks and a flushed writer both release their register this cycle.
    always_comb begin
        clr_vec = '0;
        if (wb_valid && wb_rd != '0)
            clr_vec[wb_rd] = 1'b1;
        if (flush && out_valid && out_rd_wen && out_rd != '0)
            clr_vec[out_rd] = 1'b1;
    end

    assign eff_busy = busy & ~clr_vec;
    assign hazard   = eff_busy[in_rs1] | eff_busy[in_rs2] | (in_rd_wen & eff_busy[in_rd]);
    assign in_ready = !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        set_vec = '0;
        if (accept && in_rd_wen && in_rd != '0)
            set_vec[in_rd] = 1'b1;
    end

    // Set is OR-ed after the clear so a same-cycle reissue keeps the bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy <= '0;
        else
            busy <= eff_busy | set_vec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_inst   <= '0;
            out_rs1    <= '0;
            out_rs2    <= '0;
            out_rd     <= '0;
            out_rd_wen <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_inst   <= in_inst;
            out_rs1    <= in_rs1;
            out_rs2    <= in_rs2;
            out_rd     <= in_rd;
            out_rd_wen <= in_rd_wen;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (in_valid && hazard && !flush)
            stall_cnt <= stall_cnt + 32'd1;
    end

    assign busy_mask = busy;

endmodule

// File: tb/tb_ysyx_23060077_riscv_issue_ctrl.sv
// Bench for the issue controller: directed scenarios plus random traffic,
// all checked against a pending-writer reference model.
module tb_ysyx_23060077_riscv_issue_ctrl;

    localparam int AW = 5;
    localparam int NR = 32;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_inst;
    logic [AW-1:0] in_rs1, in_rs2, in_rd;
    logic          in_rd_wen;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_inst;
    logic [AW-1:0] out_rs1, out_rs2, out_rd;
    logic          out_rd_wen;
    logic          wb_valid;
    logic [AW-1:0] wb_rd;
    logic          flush;
    logic [NR-1:0] busy_mask;
    logic [31:0]   stall_cnt;

    always #5 clk = ~clk;

    ysyx_23060077_riscv_issue_ctrl #(
        .REG_ADDR_WIDTH(AW), .NR_REG(NR), .INST_WIDTH(IW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_rd_wen(out_rd_wen),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .busy_mask(busy_mask), .stall_cnt(stall_cnt)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: which registers have an outstanding writer, plus the held instruction.
    bit            pend [NR];
    bit            m_ov;
    logic [IW-1:0] m_inst;
    logic [AW-1:0] m_rs1, m_rs2, m_rd;
    bit            m_wen;
    logic [31:0]   m_stall;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NR; r++) pend[r] = 1'b0;
        m_ov = 0; m_inst = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_wen = 0; m_stall = '0;
    endtask

    function automatic bit released(int r);
        return (wb_valid && int'(wb_rd) == r) || (flush && m_ov && m_wen && int'(m_rd) == r);
    endfunction

    function automatic bit blocked(int r);
        return r != 0 && pend[r] && !released(r);
    endfunction

    function automatic bit model_hazard();
        return blocked(int'(in_rs1)) || blocked(int'(in_rs2)) || (in_rd_wen && blocked(int'(in_rd)));
    endfunction

    function automatic logic [NR-1:0] model_mask();
        logic [NR-1:0] m = '0;
        for (int r = 1; r < NR; r++) m[r] = pend[r];
        return m;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, out_valid, m_ov);
        check({tag, ".out_inst"}, out_inst, m_inst);
        check({tag, ".out_regs"}, {out_rs1, out_rs2, out_rd, out_rd_wen}, {m_rs1, m_rs2, m_rd, m_wen});
        check({tag, ".busy_mask"}, busy_mask, model_mask());
        check({tag, ".stall_cnt"}, stall_cnt, m_stall);
    endtask

    task automatic drive(input bit v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] rd, input bit wen, input bit ordy,
                         input bit wbv, input logic [AW-1:0] wbr, input bit fl);
        in_valid = v; in_inst = $urandom; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_rd_wen = wen; out_ready = ordy; wb_valid = wbv; wb_rd = wbr; flush = fl;
    endtask

    // Called just after a falling edge with inputs already driven; ends at the next falling edge.
    task automatic step(input string tag);
        bit rdy, haz, acc;
        bit nb [NR];
        #1;
        haz = model_hazard();
        rdy = !flush && !haz && (!m_ov || out_ready);
        acc = in_valid && rdy;
        check({tag, ".in_ready"}, in_ready, rdy);
        for (int r = 0; r < NR; r++) nb[r] = pend[r] && !released(r);
        if (acc && in_rd_wen && in_rd != 0) nb[in_rd] = 1'b1;
        if (in_valid && haz && !flush) m_stall = m_stall + 1;
        if (flush) m_ov = 0;
        else if (acc) begin
            m_ov = 1; m_inst = in_inst; m_rs1 = in_rs1; m_rs2 = in_rs2; m_rd = in_rd; m_wen = in_rd_wen;
        end else if (out_ready) m_ov = 0;
        for (int r = 0; r < NR; r++) pend[r] = nb[r];
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("reset");
        rst = 1'b0;

        // addi x5
        drive(1, 0, 0, 5, 1, 1, 0, 0, 0);
        step("addi");
        check("addi.busy", busy_mask, 32'h20);

        // RAW: add x6, x5, x1 stalls until x5 writes back
        drive(1, 5, 1, 6, 1, 1, 0, 0, 0);
        step("raw0");
        step("raw1");
        check("raw.stall", stall_cnt, 32'd2);
        drive(1, 5, 1, 6, 1, 1, 1, 5, 0);
        #1 check("raw.release", in_ready, 1'b1);
        step("raw_wb");
        check("raw.busy", busy_mask, 32'h40);

        // WAW on x6, then x0 destination/source never stall
        drive(1, 0, 0, 6, 1, 1, 0, 0, 0);
        step("waw");
        drive(1, 0, 0, 0, 1, 1, 0, 0, 0);
        step("x0dst");
        check("x0.bit0", busy_mask[0], 1'b0);

        // Backpressure: held instruction stays put
        drive(1, 0, 0, 8, 1, 0, 0, 0, 0);
        step("bp0");
        step("bp1");
        drive(1, 0, 0, 8, 1, 1, 0, 0, 0);
        step("bp_rel");

        // Flush of held x7 writer
        drive(1, 0, 0, 7, 1, 1, 0, 0, 0);
        step("fl_load");
        drive(1, 0, 0, 3, 1, 0, 0, 0, 1);
        #1 check("flush.rdy", in_ready, 1'b0);
        step("flush");
        check("flush.bit7", busy_mask[7], 1'b0);

        // Writeback and reissue of x9 in the same cycle
        drive(1, 0, 0, 9, 1, 1, 0, 0, 0);
        step("x9a");
        drive(1, 0, 0, 9, 1, 1, 1, 9, 0);
        step("x9b");
        check("x9.bit", busy_mask[9], 1'b1);

        // Random traffic over a small register window to provoke collisions
        for (int i = 0; i < 3000; i++) begin
            logic [AW-1:0] lim;
            lim = ($urandom_range(0, 9) == 0) ? AW'(31) : AW'(7);
            drive($urandom_range(0, 9) < 8,
                  AW'($urandom_range(0, int'(lim))), AW'($urandom_range(0, int'(lim))),
                  AW'($urandom_range(0, int'(lim))), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
                  AW'($urandom_range(0, int'(lim))), $urandom_range(0, 19) == 0);
            step("rand");
        end

        // Reset asserted in the middle of a stall
        drive(0, 0, 0, 0, 0, 1, 1, 0, 0);
        step("pre_rst");
        drive(1, 0, 0, 10, 1, 1, 0, 0, 0);
        step("rst_ld");
        drive(1, 10, 0, 11, 1, 1, 0, 0, 0);
        step("rst_stall");
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("rst.out_valid", out_valid, 1'b0);
        check("rst.fields", {out_inst, out_rs1, out_rs2, out_rd, out_rd_wen}, '0);
        check("rst.busy", busy_mask, '0);
        check("rst.stall", stall_cnt, '0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 10, 0, 11, 1, 1, 0, 0, 0);
        step("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ysyx_23060077_riscv_issue_ctrl.md
# ysyx_23060077_riscv_issue_ctrl

Issue controller between the decode stage and execute. It takes decoded register fields (rs1, rs2, rd, rd_wen) and the instruction from decode over a valid/ready handshake, and tracks outstanding register writes in a per-register busy scoreboard. It stalls any instruction with a RAW or WAW hazard until the matching writeback arrives, and hands hazard-free instructions to execute through a one-entry output register.

## Interface
- `REG_ADDR_WIDTH`, default 5: register index width.
- `NR_REG`, default 32: number of architectural registers, equal to 2^REG_ADDR_WIDTH.
- `INST_WIDTH`, default 32: instruction width.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  decode presents an instruction.
- `in_ready`  out  1  controller accepts this cycle; combinational.
- `in_inst`  in  INST_WIDTH  instruction word.
- `in_rs1`, `in_rs2`  in  REG_ADDR_WIDTH each  source registers. Decode drives 0 for unused sources.
- `in_rd`  in  REG_ADDR_WIDTH  destination register.
- `in_rd_wen`  in  1  instruction writes rd.
- `out_valid`  out  1  output register holds an instruction.
- `out_ready`  in  1  execute accepts.
- `out_inst`, `out_rs1`, `out_rs2`, `out_rd`, `out_rd_wen`  out  as the corresponding inputs  registered copies of the accepted fields.
- `wb_valid`  in  1  a register write retires this cycle.
- `wb_rd`  in  REG_ADDR_WIDTH  register being written back.
- `flush`  in  1  kill the instruction held in the output register.
- `busy_mask`  out  NR_REG  current scoreboard; bit 0 is always 0.
- `stall_cnt`  out  32  count of hazard-stall cycles.

## Operation
- Scoreboard `busy[NR_REG-1:0]`. Register x0 is never busy.
- `clr_vec` is the set of registers cleared this cycle:
  - bit `wb_rd` when `wb_valid` and `wb_rd != 0`;
  - bit `out_rd` when `flush && out_valid && out_rd_wen && out_rd != 0`.
- `eff_busy = busy & ~clr_vec`. A writeback therefore releases a waiting instruction in the same cycle.
- `hazard` is set when any of these holds:
  - `eff_busy[in_rs1]`;
  - `eff_busy[in_rs2]`;
  - `in_rd_wen && eff_busy[in_rd]` (WAW).
- `in_ready = !flush && !hazard && (!out_valid || out_ready)`.
- An accept is `in_valid && in_ready`. On accept:
  - the output register loads all in_* fields;
  - `out_valid` goes to 1;
  - if `in_rd_wen && in_rd != 0`, the set vector marks `busy[in_rd]`.
- Busy update: `busy_next = (busy & ~clr_vec) | set_vec`. Set wins over clear on the same index.
- When `out_valid && out_ready` with no accept in the same cycle, `out_valid` goes to 0. Fields hold their last values.
- Flush:
  - `out_valid` goes to 0;
  - the busy bit of the killed instruction is cleared, as defined by `clr_vec`;
  - no accept occurs in that cycle;
  - execute also receives flush and ignores any transfer in that cycle.
- WAW stalling guarantees at most one outstanding writer per register. A writeback therefore always clears the correct bit. A writeback to a non-busy register is a no-op.
- `stall_cnt` increments by 1 on each cycle with `in_valid && hazard && !flush`, and wraps from 0xFFFFFFFF to 0.

## Timing
- Reset values: busy = 0, `out_valid` = 0, all out_* fields = 0, `stall_cnt` = 0.
- Reset asserted mid-stall or mid-transfer discards everything immediately.
- Latency: an instruction accepted in cycle N appears with `out_valid` = 1 in cycle N+1.
- Throughput: one instruction per cycle when there are no hazards and `out_ready` = 1.
- Back-to-back issue: the output register is freed and reloaded in the same cycle when `out_ready` = 1.
- A dependent instruction issues in the same cycle as the writeback that releases it. It never issues earlier.
- `busy_mask` reflects registered state: a bit set by an accept in cycle N is visible in cycle N+1.
- `in_ready` has no dependence on `in_valid`.

## Test plan
- Reset, then issue `addi x5` (rd_wen = 1) with `out_ready` = 1 → `out_valid` = 1 next cycle; `busy_mask` = 0x20.
- RAW: with x5 busy, present `add x6, x5, x1` → `in_ready` = 0, `stall_cnt` increments each cycle. Pulse `wb_valid`, `wb_rd` = 5 → `in_ready` = 1 that same cycle; `busy_mask` = 0x40 next cycle.
- WAW on x5 while x5 is busy → stall. x0-destination and x0-source instructions never stall; `busy_mask` bit 0 stays 0.
- Backpressure: hold `out_ready` = 0 with `out_valid` = 1 → `in_ready` = 0 and out_* fields stable. Release → the next instruction loads in that cycle.
- Flush with the held instruction writing x7 → `out_valid` = 0 next cycle; `busy_mask` bit 7 clears; `in_ready` = 0 during the flush cycle.
- Simultaneous events:
  - `wb_rd` = 9 and an accept with `in_rd` = 9 in the same cycle → bit 9 remains 1;
  - assert `rst` mid-stall → all outputs are 0 immediately.
